ysyx_22050039_idu: RTL and testbench

Instruction decode and issue unit feeding the execute stage of the ysyx_22050039 RV64 core. It accepts one instruction word from the fetch side over a valid/ready handshake and decodes it. It reads operands from an internal 32×XLEN register file and presents registered `func/src1/src2/rd` to the EXU over a second valid/ready handshake. It holds one instruction in flight and waits for write-back before accepting the next, so no RAW hazard logic is needed.

---
 rtl/ysyx_22050039_pkg.sv | 18 +
 rtl/ysyx_22050039_RegisterFile.sv | 37 +++
 rtl/ysyx_22050039_idu.sv | 149 ++++++++++++++
 tb/tb_ysyx_22050039_idu.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050039_pkg.sv
// Shared decode constants and FSM state type for the ysyx_22050039 decode/issue unit.
package ysyx_22050039_pkg;

  localparam logic [6:0]  OP_IMM      = 7'b0010011;
  localparam logic [2:0]  F3_ADDI     = 3'b000;
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  localparam logic FUNC_ADD    = 1'b1;
  localparam logic FUNC_EBREAK = 1'b0;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitWb,
    StHalt
  } idu_state_e;

endpackage

// File: rtl/ysyx_22050039_RegisterFile.sv
// 32-entry integer register file: one combinational read port, one write port, x0 reads zero.
module ysyx_22050039_RegisterFile #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] regs_q [32];
  logic [XLEN-1:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != 5'd0)) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata = (raddr == 5'd0) ? '0 : regs_q[raddr];

endmodule

// File: rtl/ysyx_22050039_idu.sv
// Decode/issue unit: one instruction in flight, ADDI and EBREAK only.
// Optional illegal-instruction trap enabled by YSYX_22050039_IDU_ILLEGAL_TRAP_EN.
module ysyx_22050039_idu
  import ysyx_22050039_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_func,
  output logic [XLEN-1:0] out_src1,
  output logic [XLEN-1:0] out_src2,
  output logic [4:0]      out_rd,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            halted,
  output logic            illegal
);

  idu_state_e      state_q, state_d;
  logic            func_q, func_d;
  logic [XLEN-1:0] src1_q, src1_d;
  logic [XLEN-1:0] src2_q, src2_d;
  logic [4:0]      rd_q, rd_d;
  logic            halted_q, halted_d;
  logic [XLEN-1:0] rs1_data;
  logic            is_addi, is_ebreak;

  ysyx_22050039_RegisterFile #(
    .XLEN (XLEN)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (wb_valid),
    .waddr (wb_rd),
    .wdata (wb_data),
    .raddr (in_inst[19:15]),
    .rdata (rs1_data)
  );

  assign is_addi   = (in_inst[6:0] == OP_IMM) && (in_inst[14:12] == F3_ADDI);
  assign is_ebreak = (in_inst == EBREAK_INST);

`ifdef YSYX_22050039_IDU_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    rd_d     = rd_q;
    halted_d = halted_q;
`ifdef YSYX_22050039_IDU_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (is_addi) begin
            func_d  = FUNC_ADD;
            src1_d  = rs1_data;
            src2_d  = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
            rd_d    = in_inst[11:7];
            state_d = StIssue;
          end else if (is_ebreak) begin
            func_d  = FUNC_EBREAK;
            src1_d  = '0;
            src2_d  = '0;
            rd_d    = '0;
            state_d = StIssue;
          end else begin
`ifdef YSYX_22050039_IDU_ILLEGAL_TRAP_EN
            illegal_d = 1'b1;
            halted_d  = 1'b1;
            state_d   = StHalt;
`endif
          end
        end
      end
      StIssue: begin
        if (out_ready) begin
          if (func_q == FUNC_ADD) begin
            state_d = StWaitWb;
          end else begin
            halted_d = 1'b1;
            state_d  = StHalt;
          end
        end
      end
      StWaitWb: begin
        if (wb_valid) begin
          state_d = StIdle;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      func_q   <= 1'b0;
      src1_q   <= '0;
      src2_q   <= '0;
      rd_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      rd_q     <= rd_d;
      halted_q <= halted_d;
    end
  end

`ifdef YSYX_22050039_IDU_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StIssue);
  assign out_func  = func_q;
  assign out_src1  = src1_q;
  assign out_src2  = src2_q;
  assign out_rd    = rd_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_ysyx_22050039_idu.sv
// Scoreboard bench for ysyx_22050039_idu: stimulus pushes expected bundles, a monitor checks them.
module tb_ysyx_22050039_idu;

  localparam int unsigned XLEN = 64;

  typedef struct packed {
    logic            func;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [4:0]      rd;
  } bundle_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_inst = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            out_func;
  logic [XLEN-1:0] out_src1;
  logic [XLEN-1:0] out_src2;
  logic [4:0]      out_rd;
  logic            wb_valid = 1'b0;
  logic [4:0]      wb_rd = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic            halted;
  logic            illegal;

  int n_tests = 0;
  int n_fail  = 0;
  bundle_t exp_q[$];

  ysyx_22050039_idu #(
    .XLEN (XLEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_func  (out_func),
    .out_src1  (out_src1),
    .out_src2  (out_src2),
    .out_rd    (out_rd),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .halted    (halted),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every cycle the bundle is offered it must equal the queue head; pop on handshake.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", {63'd0, out_valid}, '0);
      end else begin
        chk("bundle_func", {63'd0, out_func}, {63'd0, exp_q[0].func});
        chk("bundle_src1", out_src1, exp_q[0].src1);
        chk("bundle_src2", out_src2, exp_q[0].src2);
        chk("bundle_rd", {59'd0, out_rd}, {59'd0, exp_q[0].rd});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    if (!in_ready) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
  endtask

  // Accept one instruction, stall the EXU for 'stall' cycles, then complete the handshake.
  task automatic issue(input logic [31:0] inst, input bundle_t exp, input int stall);
    wait_ready();
    exp_q.push_back(exp);
    in_inst  = inst;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("issue_latency", {63'd0, out_valid}, 64'd1);
    chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("out_valid_drop", {63'd0, out_valid}, 64'd0);
  endtask

  task automatic writeback(input logic [4:0] rd, input logic [XLEN-1:0] data);
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_data  = data;
    @(posedge clk);
    #1 wb_valid = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk("rst_illegal", {63'd0, illegal}, 64'd0);
    chk("rst_func", {63'd0, out_func}, 64'd0);
    chk("rst_src1", out_src1, 64'd0);
    chk("rst_src2", out_src2, 64'd0);
    chk("rst_rd", {59'd0, out_rd}, 64'd0);

    // addi x1,x0,5 with a 3-cycle EXU stall
    issue(32'h0050_0093, '{func: 1'b1, src1: 64'd0, src2: 64'd5, rd: 5'd1}, 3);
    @(posedge clk);
    #1 chk("wait_wb_hold", {63'd0, in_ready}, 64'd0);
    writeback(5'd1, 64'd5);
    chk("wb_to_ready", {63'd0, in_ready}, 64'd1);

    // addi x2,x1,-1 reads the just-written x1
    issue(32'hFFF0_8113, '{func: 1'b1, src1: 64'd5, src2: 64'hFFFF_FFFF_FFFF_FFFF, rd: 5'd2}, 0);
    writeback(5'd0, 64'h1234);
    chk("wb_x0_advances", {63'd0, in_ready}, 64'd1);

    // addi x3,x0,0: x0 untouched by the write above
    issue(32'h0000_0193, '{func: 1'b1, src1: 64'd0, src2: 64'd0, rd: 5'd3}, 1);
    writeback(5'd2, 64'h0000_0000_DEAD_BEEF);

    // addi x4,x2,2047: max positive immediate
    issue(32'h7FF1_0213, '{func: 1'b1, src1: 64'hDEAD_BEEF, src2: 64'h7FF, rd: 5'd4}, 0);
    writeback(5'd4, 64'd1);

    // write-back while IDLE updates x5 but leaves the FSM alone
    writeback(5'd5, 64'h55);
    chk("idle_wb_ready", {63'd0, in_ready}, 64'd1);
    chk("idle_wb_no_issue", {63'd0, out_valid}, 64'd0);

    // illegal instruction
    in_inst  = 32'hFFFF_FFFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("illegal_no_issue", {63'd0, out_valid}, 64'd0);
`ifdef YSYX_22050039_IDU_ILLEGAL_TRAP_EN
    chk("illegal_flag", {63'd0, illegal}, 64'd1);
    chk("illegal_halted", {63'd0, halted}, 64'd1);
    chk("illegal_in_ready", {63'd0, in_ready}, 64'd0);
    do_reset();
    writeback(5'd5, 64'h55);
`else
    chk("illegal_flag", {63'd0, illegal}, 64'd0);
    chk("illegal_halted", {63'd0, halted}, 64'd0);
    chk("illegal_in_ready", {63'd0, in_ready}, 64'd1);
`endif

    // addi x6,x5,-2048: min negative immediate
    issue(32'h8002_8313, '{func: 1'b1, src1: 64'h55, src2: 64'hFFFF_FFFF_FFFF_F800, rd: 5'd6}, 0);
    writeback(5'd6, 64'd7);

    // EBREAK halts after the handshake and blocks further input
    issue(32'h0010_0073, '{func: 1'b0, src1: 64'd0, src2: 64'd0, rd: 5'd0}, 1);
    chk("ebreak_halted", {63'd0, halted}, 64'd1);
    in_inst  = 32'h0050_0093;
    in_valid = 1'b1;
    wb_valid = 1'b1;
    wb_rd    = 5'd9;
    wb_data  = 64'h99;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (in_ready || out_valid || !halted)
        chk("halt_hold", {61'd0, in_ready, out_valid, halted}, 64'd1);
      else
        chk("halt_hold", {61'd0, in_ready, out_valid, halted}, 64'd1);
    end
    in_valid = 1'b0;
    wb_valid = 1'b0;

    // reset clears halt and the register file: addi x7,x1,0 reads 0
    do_reset();
    chk("rerst_halted", {63'd0, halted}, 64'd0);
    chk("rerst_in_ready", {63'd0, in_ready}, 64'd1);
    issue(32'h0000_8393, '{func: 1'b1, src1: 64'd0, src2: 64'd0, rd: 5'd7}, 0);
    writeback(5'd7, 64'd0);

    repeat (2) @(posedge clk);
    #1 chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
